// File: rtl/acc_ctrl_fsm.sv
// acc_ctrl_fsm: multi-cycle control FSM for the 16-bit accumulator core; ACC_CTRL_ILLEGAL_TRAP_EN traps illegal opcodes into HALT
module acc_ctrl_fsm #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                zero,
  output logic                pc_write,
  output logic [1:0]          pc_src_sel,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                acc_write,
  output logic [2:0]          acc_src_sel,
  output logic [2:0]          alu_op,
  output logic [2:0]          state,
  output logic                halted,
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  output logic                illegal,
`endif
  output logic [RETIRE_W-1:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t cur, nxt;
  logic [3:0] op;
  logic unused_imm;
  assign op = instr[15:12];
  assign unused_imm = ^instr[11:0];
  assign state = cur;
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_op, illegal_q;
  assign illegal_op = op inside {[4'hA:4'hE]};
  assign illegal = illegal_q & ~reset;
`endif
  always_comb begin
    nxt = FETCH;
    pc_write = 1'b0;
    pc_src_sel = 2'b00;
    ir_write = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    acc_write = 1'b0;
    acc_src_sel = 3'b000;
    alu_op = 3'b000;
    halted = 1'b0;
    case (cur)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
        nxt = DECODE;
      end
      DECODE: begin
        case (op)
          4'h1: begin
            acc_write = 1'b1;
            acc_src_sel = 3'b001;
          end
          4'h8: begin
            pc_write = zero;
            pc_src_sel = 2'b10;
          end
          4'h9: begin
            pc_write = 1'b1;
            pc_src_sel = 2'b01;
          end
          4'h2, 4'h3: nxt = MEM;
          4'h4, 4'h5, 4'h6, 4'h7: nxt = EXEC;
          4'hF: nxt = HALT;
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
          default: nxt = illegal_op ? HALT : FETCH;
`else
          default: nxt = FETCH;
`endif
        endcase
      end
      EXEC: begin
        alu_op = {1'b0, op[1:0]};
        nxt = WB;
      end
      MEM: begin
        mem_read = op == 4'h2;
        mem_write = op != 4'h2;
        nxt = op == 4'h2 ? WB : FETCH;
      end
      WB: begin
        acc_write = 1'b1;
        acc_src_sel = op == 4'h2 ? 3'b010 : 3'b000;
        alu_op = op == 4'h2 ? 3'b000 : {1'b0, op[1:0]};
      end
      HALT: begin
        halted = 1'b1;
        nxt = HALT;
      end
      default: nxt = FETCH;
    endcase
    // reset aborts the current step: nothing reaches the datapath
    if (reset) begin
      pc_write = 1'b0;
      pc_src_sel = 2'b00;
      ir_write = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      acc_write = 1'b0;
      acc_src_sel = 3'b000;
      alu_op = 3'b000;
      halted = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if ((nxt == FETCH && cur != FETCH) || (nxt == HALT && cur != HALT))
        retired <= retired + RETIRE_W'(1);
    end
  end
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else if (cur == DECODE && illegal_op) illegal_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// tb_acc_ctrl_fsm: directed checks of acc_ctrl_fsm sequencing, strobes and retired count
module tb_acc_ctrl_fsm;
  logic clk = 1'b0;
  logic reset, zero;
  logic [15:0] instr;
  logic pc_write, ir_write, mem_read, mem_write, acc_write, halted;
  logic [1:0] pc_src_sel;
  logic [2:0] acc_src_sel, alu_op, state;
  logic [15:0] retired;
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  logic illegal;
`endif
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ret = '0;
  logic [4:0] strobes;
  assign strobes = {pc_write, ir_write, mem_read, mem_write, acc_write};

  acc_ctrl_fsm #(.RETIRE_W(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .pc_write(pc_write), .pc_src_sel(pc_src_sel), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .acc_write(acc_write),
    .acc_src_sel(acc_src_sel), .alu_op(alu_op), .state(state),
    .halted(halted),
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    zero = 1'b0;
    instr = 16'h0000;
    tick();
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", 32'(strobes), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retired", 32'(retired), 0);
    reset = 1'b0;
    #1;
    chk("nop_fetch_strobes", 32'(strobes), 32'b11100);
    chk("nop_fetch_pcsel", 32'(pc_src_sel), 0);
    tick();
    chk("nop_decode_state", 32'(state), 1);
    chk("nop_decode_strobes", 32'(strobes), 0);
    tick();
    exp_ret++;
    chk("nop_back_fetch", 32'(state), 0);
    chk("nop_retired", 32'(retired), 32'(exp_ret));
    instr = 16'h1005;
    tick();
    chk("loadi_strobes", 32'(strobes), 32'b00001);
    chk("loadi_src", 32'(acc_src_sel), 1);
    tick();
    exp_ret++;
    chk("loadi_fetch", 32'(state), 0);
    chk("loadi_retired", 32'(retired), 32'(exp_ret));
    instr = 16'h4010;
    tick();
    chk("add_decode", 32'(state), 1);
    tick();
    chk("add_exec", 32'(state), 2);
    chk("add_exec_alu", 32'(alu_op), 0);
    chk("add_exec_strobes", 32'(strobes), 0);
    tick();
    chk("add_wb", 32'(state), 4);
    chk("add_wb_strobes", 32'(strobes), 32'b00001);
    chk("add_wb_src", 32'(acc_src_sel), 0);
    chk("add_wb_alu", 32'(alu_op), 0);
    tick();
    exp_ret++;
    chk("add_fetch", 32'(state), 0);
    chk("add_retired", 32'(retired), 32'(exp_ret));
    instr = 16'h5010;
    tick();
    tick();
    chk("sub_exec_alu", 32'(alu_op), 1);
    tick();
    chk("sub_wb_alu", 32'(alu_op), 1);
    tick();
    exp_ret++;
    instr = 16'h7010;
    tick();
    tick();
    chk("or_exec_alu", 32'(alu_op), 3);
    tick();
    tick();
    exp_ret++;
    chk("or_retired", 32'(retired), 32'(exp_ret));
    instr = 16'h2020;
    tick();
    chk("load_decode_strobes", 32'(strobes), 0);
    tick();
    chk("load_mem", 32'(state), 3);
    chk("load_mem_strobes", 32'(strobes), 32'b00100);
    tick();
    chk("load_wb", 32'(state), 4);
    chk("load_wb_strobes", 32'(strobes), 32'b00001);
    chk("load_wb_src", 32'(acc_src_sel), 2);
    tick();
    exp_ret++;
    chk("load_retired", 32'(retired), 32'(exp_ret));
    instr = 16'h3020;
    tick();
    chk("store_decode_strobes", 32'(strobes), 0);
    tick();
    chk("store_mem", 32'(state), 3);
    chk("store_mem_strobes", 32'(strobes), 32'b00010);
    tick();
    exp_ret++;
    chk("store_fetch", 32'(state), 0);
    chk("store_retired", 32'(retired), 32'(exp_ret));
    instr = 16'h8003;
    zero = 1'b1;
    tick();
    chk("beqz_taken_pcw", 32'(pc_write), 1);
    chk("beqz_taken_sel", 32'(pc_src_sel), 2);
    tick();
    exp_ret++;
    zero = 1'b0;
    tick();
    chk("beqz_not_pcw", 32'(pc_write), 0);
    tick();
    exp_ret++;
    chk("beqz_fetch", 32'(state), 0);
    instr = 16'h9000;
    tick();
    chk("jmp_pcw", 32'(pc_write), 1);
    chk("jmp_sel", 32'(pc_src_sel), 1);
    tick();
    exp_ret++;
    chk("jmp_retired", 32'(retired), 32'(exp_ret));
    instr = 16'hB000;
    tick();
    chk("illegal_decode_strobes", 32'(strobes), 0);
    tick();
    exp_ret++;
    chk("illegal_retired", 32'(retired), 32'(exp_ret));
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
    chk("illegal_halt_state", 32'(state), 5);
    chk("illegal_halted", 32'(halted), 1);
    chk("illegal_flag", 32'(illegal), 1);
    tick();
    chk("illegal_sticky", 32'(illegal), 1);
    reset = 1'b1;
    tick();
    chk("illegal_cleared", 32'(illegal), 0);
    reset = 1'b0;
    exp_ret = '0;
    #1;
`else
    chk("illegal_as_nop", 32'(state), 0);
`endif
    instr = 16'hF000;
    tick();
    tick();
    exp_ret++;
    chk("halt_state", 32'(state), 5);
    chk("halt_retired", 32'(retired), 32'(exp_ret));
    for (int i = 0; i < 10; i++) begin
      chk("halt_hold_strobes", 32'(strobes), 0);
      chk("halt_hold_halted", 32'(halted), 1);
      tick();
    end
    chk("halt_stay", 32'(state), 5);
    chk("halt_retired_stable", 32'(retired), 32'(exp_ret));
    reset = 1'b1;
    #1;
    chk("halt_reset_halted", 32'(halted), 0);
    tick();
    chk("halt_reset_state", 32'(state), 0);
    chk("halt_reset_retired", 32'(retired), 0);
    reset = 1'b0;
    instr = 16'h4010;
    tick();
    tick();
    tick();
    chk("abort_wb", 32'(state), 4);
    reset = 1'b1;
    #1;
    chk("abort_strobes", 32'(strobes), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(state), 0);
    chk("abort_retired", 32'(retired), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
